nco_sweep_controller: RTL and testbench
=======================================

# nco_sweep_controller

Frequency-sweep sequencer for `lut_based_nco`. It drives the NCO's signed phase-step input through a programmed sequence from a start step to a stop step, holding each value for a programmed dwell. It supports single-shot, repeating-sawtooth and bouncing-triangle sweeps. It sits directly in front of the NCO: its `ostep` connects to the NCO step port, and a host or test sequencer issues start/abort commands.

## Interface

- `STEP_WIDTH`, 9: width of the signed step. Equals NCO integer phase bits (6) + fractional bits (2) + 1 sign bit.
- `DWELL_WIDTH`, 16: width of the dwell count.
- `iclk`  in  1  clock; all logic on the rising edge.
- `ireset`  in  1  synchronous reset, active-high.
- `istart`  in  1  start pulse; sampled only in IDLE.
- `iabort`  in  1  abort; takes effect from any non-IDLE state.
- `istep_start`  in  STEP_WIDTH  signed first step value.
- `istep_stop`  in  STEP_WIDTH  signed final step value.
- `istep_inc`  in  STEP_WIDTH  signed increment.
- `idwell`  in  DWELL_WIDTH  each step value is held `idwell+1` cycles.
- `imode`  in  2  sweep mode: 00 single, 01 repeat (saw), 10 bounce (triangle), 11 treated as single.
- `ostep`  out  STEP_WIDTH  signed step to the NCO; registered.
- `ostep_update`  out  1  one-cycle pulse in the first cycle a new `ostep` value is presented.
- `obusy`  out  1  high while a sweep is running.
- `odone`  out  1  one-cycle pulse when a single-shot sweep completes.

## Operation

- States: IDLE, DWELL, DONE.
- Reset: state=IDLE, `ostep`=0, `ostep_update`=0, `obusy`=0, `odone`=0, dwell counter=0.
- IDLE + `istart` (and not `iabort`):
  - latch start, stop, inc (inc sign-extended to STEP_WIDTH+1), dwell and mode;
  - `ostep`←start, counter←idwell, `ostep_update`=1, go to DWELL.
- DWELL:
  - counter≠0: decrement; `ostep` held.
  - counter=0 and `ostep`≠stop: compute next=`ostep`+inc in STEP_WIDTH+1 bits.
    - Clamp: if inc>0 and next≥stop, or inc<0 and next≤stop, next=stop.
    - `ostep`←next, counter←dwell, pulse `ostep_update`.
  - counter=0 and `ostep`=stop, by mode:
    - single: go to DONE.
    - repeat: `ostep`←start, reload counter, pulse `ostep_update`.
    - bounce: swap latched start/stop, inc←−inc (STEP_WIDTH+1 bits, so −2^(W−1) negates safely); `ostep`←next value along the new direction, clamped as above; reload counter; pulse `ostep_update`.
- DONE (one cycle): `odone`=1, `ostep`=0, `obusy`=0; next state IDLE.
- Boundary rules:
  - inc=0: first update clamps to stop, so the sweep is start then stop, then terminates per mode.
  - Direction mismatch (e.g. inc>0, stop<start): the first update clamps to stop.
  - start=stop: one dwell of start, then terminate per mode. In bounce mode this value is held indefinitely.
- `iabort` in DWELL: next cycle IDLE, `ostep`=0, `obusy`=0, no `odone`, no `ostep_update`.
- `istart` while not IDLE: ignored. Latched config is unaffected by input changes during a sweep.
- `iabort` with `istart` in IDLE: abort wins; stays IDLE.
- `ireset` overrides everything in any state.

## Timing

- `istart` sampled at edge t. From t+1: `ostep`=start, `obusy`=1, `ostep_update`=1.
- Each value is held exactly `idwell+1` cycles. Updates are back-to-back with no gap cycle.
- Single mode, N distinct values: `odone` high at cycle t+1+N·(idwell+1); `ostep` returns to 0 in that same cycle.
- `obusy` is high exactly during DWELL.
- Earliest restart: an `istart` in the cycle after DONE is accepted.

## Structure

- Shared package `nco_pkg`:
  - NCO constants: LUT_LENGTH=6, LUT_WIDTH=15, fractional phase bits=2, derived STEP_WIDTH.
  - Mode encodings.
  - State enum.
- One natural sub-module: `nco_dwell_timer` (load/decrement counter with a zero flag).
- Clamp/next-step arithmetic stays in the top level.

## Test plan

- Single: start=1, stop=7, inc=1, dwell=3 → `ostep` 1..7, each for 4 cycles. `odone` at t+29 with `ostep`=0. `obusy` high t+1..t+28.
- Clamp and negative direction:
  - start=0, stop=8, inc=3, dwell=0 → 0,3,6,8, `odone` at t+5.
  - start=2, stop=−2 (9'b111111110), inc=−1, dwell=1 → 2,1,0,−1,−2, each for 2 cycles.
- Bounce: start=1, stop=3, inc=1, dwell=0 → 1,2,3,2,1,2,3…; `ostep_update` every cycle; never `odone`. Abort → `ostep`=0 next cycle.
- Repeat: start=−3, stop=0, inc=1, dwell=2 → −3..0 then −3 again. `istart` mid-sweep with different config is ignored; the sweep is unchanged.
- Corners:
  - inc=0 single → start, then stop, then done.
  - `istart`+`iabort` in the same IDLE cycle → stays IDLE.
- Reset: `ireset` mid-DWELL → next cycle all outputs 0, IDLE. A new `istart` then runs normally.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared constants and encodings for the LUT-based NCO and its sweep controller.
package nco_pkg;

    localparam int LUT_LENGTH      = 6;
    localparam int LUT_WIDTH       = 15;
    localparam int PHASE_FRAC_BITS = 2;
    // Signed phase step: integer phase bits + fractional bits + sign.
    localparam int NCO_STEP_WIDTH  = LUT_LENGTH + PHASE_FRAC_BITS + 1;
    localparam int NCO_DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_REPEAT = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } sweep_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DWELL = 2'b01,
        ST_DONE  = 2'b10
    } sweep_state_e;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter with a zero flag; paces how long each sweep value is held.
module nco_dwell_timer
    import nco_pkg::*;
#(
    parameter int WIDTH = NCO_DWELL_WIDTH
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             iload,
    input  logic [WIDTH-1:0] iload_val,
    output logic             ozero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (iload) begin
            count_d = iload_val;
        end else if (count_q != {WIDTH{1'b0}}) begin
            count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign ozero = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/nco_sweep_controller.sv
// Frequency-sweep sequencer driving the NCO phase-step input through
// single, sawtooth or triangle sweeps with a programmable dwell per value.
module nco_sweep_controller
    import nco_pkg::*;
#(
    parameter int STEP_WIDTH  = NCO_STEP_WIDTH,
    parameter int DWELL_WIDTH = NCO_DWELL_WIDTH
) (
    input  logic                   iclk,
    input  logic                   ireset,
    input  logic                   istart,
    input  logic                   iabort,
    input  logic [STEP_WIDTH-1:0]  istep_start,
    input  logic [STEP_WIDTH-1:0]  istep_stop,
    input  logic [STEP_WIDTH-1:0]  istep_inc,
    input  logic [DWELL_WIDTH-1:0] idwell,
    input  logic [1:0]             imode,
    output logic [STEP_WIDTH-1:0]  ostep,
    output logic                   ostep_update,
    output logic                   obusy,
    output logic                   odone
);

    localparam int W = STEP_WIDTH;

    sweep_state_e     state_q, state_d;
    sweep_mode_e      mode_q, mode_d;
    logic [W-1:0]     ostep_q, ostep_d;
    logic             upd_q, upd_d;
    logic [W-1:0]     start_q, start_d;
    logic [W-1:0]     stop_q, stop_d;
    logic [W:0]       inc_q, inc_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;

    logic                   load_s;
    logic [DWELL_WIDTH-1:0] load_val_s;
    logic                   zero_s;
    logic [W:0]             inc_neg_s;
    logic [W-1:0]           next_fwd_s;
    logic [W-1:0]           next_bnc_s;

    // Step one increment from cur toward lim; inc=0 or any overshoot lands on lim.
    // The extra bit keeps the sum and a negated most-negative increment exact.
    function automatic logic [W-1:0] clamp_step(input logic [W-1:0] cur,
                                                input logic [W:0]   inc,
                                                input logic [W-1:0] lim);
        logic signed [W:0] sum;
        logic signed [W:0] lim_x;
        sum   = $signed({cur[W-1], cur}) + $signed(inc);
        lim_x = $signed({lim[W-1], lim});
        if (inc == {(W+1){1'b0}}) begin
            return lim;
        end else if (!inc[W] && (sum >= lim_x)) begin
            return lim;
        end else if (inc[W] && (sum <= lim_x)) begin
            return lim;
        end else begin
            return sum[W-1:0];
        end
    endfunction

    assign inc_neg_s  = {(W+1){1'b0}} - inc_q;
    assign next_fwd_s = clamp_step(ostep_q, inc_q, stop_q);
    assign next_bnc_s = clamp_step(ostep_q, inc_neg_s, start_q);

    nco_dwell_timer #(
        .WIDTH (DWELL_WIDTH)
    ) u_timer (
        .iclk      (iclk),
        .ireset    (ireset),
        .iload     (load_s),
        .iload_val (load_val_s),
        .ozero     (zero_s)
    );

    // Next-state, config latch and step sequencing.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ostep_d    = ostep_q;
        upd_d      = 1'b0;
        start_d    = start_q;
        stop_d     = stop_q;
        inc_d      = inc_q;
        dwell_d    = dwell_q;
        load_s     = 1'b0;
        load_val_s = dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (istart && !iabort) begin
                    start_d    = istep_start;
                    stop_d     = istep_stop;
                    inc_d      = {istep_inc[W-1], istep_inc};
                    dwell_d    = idwell;
                    mode_d     = sweep_mode_e'(imode);
                    ostep_d    = istep_start;
                    load_s     = 1'b1;
                    load_val_s = idwell;
                    upd_d      = 1'b1;
                    state_d    = ST_DWELL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (iabort) begin
                    state_d = ST_IDLE;
                    ostep_d = {W{1'b0}};
                end else if (!zero_s) begin
                    ostep_d = ostep_q;
                end else if (ostep_q != stop_q) begin
                    ostep_d = next_fwd_s;
                    load_s  = 1'b1;
                    upd_d   = 1'b1;
                end else begin
                    case (mode_q)
                        MODE_REPEAT: begin
                            ostep_d = start_q;
                            load_s  = 1'b1;
                            upd_d   = 1'b1;
                        end
                        MODE_BOUNCE: begin
                            start_d = stop_q;
                            stop_d  = start_q;
                            inc_d   = inc_neg_s;
                            ostep_d = next_bnc_s;
                            load_s  = 1'b1;
                            upd_d   = 1'b1;
                        end
                        default: begin
                            state_d = ST_DONE;
                            ostep_d = {W{1'b0}};
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ostep_d = {W{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                ostep_d = {W{1'b0}};
            end
        endcase
    end

    // State, output and latched-config registers.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SINGLE;
            ostep_q <= {W{1'b0}};
            upd_q   <= 1'b0;
            start_q <= {W{1'b0}};
            stop_q  <= {W{1'b0}};
            inc_q   <= {(W+1){1'b0}};
            dwell_q <= {DWELL_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ostep_q <= ostep_d;
            upd_q   <= upd_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            inc_q   <= inc_d;
            dwell_q <= dwell_d;
        end
    end

    assign ostep        = ostep_q;
    assign ostep_update = upd_q;
    assign obusy        = (state_q == ST_DWELL);
    assign odone        = (state_q == ST_DONE);

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Randomized and directed bench for nco_sweep_controller against a value-list sweep model.
module tb_nco_sweep_controller;

    logic        iclk = 1'b0;
    logic        ireset, istart, iabort;
    logic [8:0]  istep_start, istep_stop, istep_inc;
    logic [15:0] idwell;
    logic [1:0]  imode;
    logic [8:0]  ostep;
    logic        ostep_update, obusy, odone;

    int   vectors = 0;
    int   miscompares = 0;
    logic chk_en = 1'b0;
    logic [8:0] exp_step = 9'd0;
    logic exp_upd = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    always #5 iclk = ~iclk;

    nco_sweep_controller dut (
        .iclk         (iclk),
        .ireset       (ireset),
        .istart       (istart),
        .iabort       (iabort),
        .istep_start  (istep_start),
        .istep_stop   (istep_stop),
        .istep_inc    (istep_inc),
        .idwell       (idwell),
        .imode        (imode),
        .ostep        (ostep),
        .ostep_update (ostep_update),
        .obusy        (obusy),
        .odone        (odone)
    );

    function automatic int clampv(input int cur, input int inc, input int lim);
        int nx;
        nx = cur + inc;
        if (inc == 0) return lim;
        if (inc > 0 && nx >= lim) return lim;
        if (inc < 0 && nx <= lim) return lim;
        return nx;
    endfunction

    // Sequence of distinct presented values; single mode stops at the stop value.
    function automatic void build_vals(input int s, input int e, input int inc, input int m,
                                       input int need, output int vals[$]);
        int cur, st, en, d, t;
        vals = {};
        cur = s; st = s; en = e; d = inc;
        vals.push_back(cur);
        while (vals.size() < need) begin
            if (cur != en) begin
                cur = clampv(cur, d, en);
            end else if (m == 1) begin
                cur = st;
            end else if (m == 2) begin
                t = st; st = en; en = t; d = -d;
                cur = clampv(cur, d, en);
            end else begin
                break;
            end
            vals.push_back(cur);
        end
    endfunction

    task automatic pin(input string nm, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL model_%s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    // Model pins, then per-cycle comparison of the DUT against the expectation.
    initial begin
        int v[$];
        int e1[4] = '{0, 3, 6, 8};
        int e2[5] = '{2, 1, 0, -1, -2};
        int e3[7] = '{1, 2, 3, 2, 1, 2, 3};
        int e4[6] = '{-3, -2, -1, 0, -3, -2};
        build_vals(1, 7, 1, 0, 1000, v);
        pin("single_len", v.size(), 7);
        pin("single_done_cycle", 1 + v.size() * 4, 29);
        build_vals(0, 8, 3, 0, 1000, v);
        pin("clamp_len", v.size(), 4);
        for (int i = 0; i < 4; i++) pin("clamp_val", v[i], e1[i]);
        pin("clamp_done_cycle", 1 + v.size(), 5);
        build_vals(2, -2, -1, 0, 1000, v);
        for (int i = 0; i < 5; i++) pin("neg_val", v[i], e2[i]);
        build_vals(1, 3, 1, 2, 7, v);
        for (int i = 0; i < 7; i++) pin("bounce_val", v[i], e3[i]);
        build_vals(-3, 0, 1, 1, 6, v);
        for (int i = 0; i < 6; i++) pin("repeat_val", v[i], e4[i]);
        build_vals(5, -4, 0, 0, 1000, v);
        pin("inc0_len", v.size(), 2);
        pin("inc0_last", v[1], -4);
        forever begin
            @(negedge iclk);
            if (chk_en) begin
                vectors++;
                if ({ostep, ostep_update, obusy, odone} !== {exp_step, exp_upd, exp_busy, exp_done}) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: step=%0d upd=%b busy=%b done=%b, expected step=%0d upd=%b busy=%b done=%b",
                             $time, $signed(ostep), ostep_update, obusy, odone,
                             $signed(exp_step), exp_upd, exp_busy, exp_done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic set_exp(input int v, input logic u, input logic b, input logic dn);
        exp_step = v[8:0];
        exp_upd  = u;
        exp_busy = b;
        exp_done = dn;
    endtask

    task automatic scramble();
        istep_start = 9'($urandom);
        istep_stop  = 9'($urandom);
        istep_inc   = 9'($urandom);
        idwell      = 16'($urandom);
        imode       = 2'($urandom);
    endtask

    // One sweep; ends after done, or on abort/reset at cycle abort_k/reset_k.
    task automatic run(input int s, input int e, input int inc, input int d, input int m,
                       input int abort_k, input int reset_k);
        int  vals[$];
        int  n, stop_k, idx;
        bit  single;
        single = (m == 0) || (m == 3);
        stop_k = (abort_k > 0) ? abort_k : reset_k;
        build_vals(s, e, inc, m, single ? 1000 : (stop_k / (d + 1) + 2), vals);
        n = vals.size();
        istep_start = s[8:0];
        istep_stop  = e[8:0];
        istep_inc   = inc[8:0];
        idwell      = d[15:0];
        imode       = m[1:0];
        istart      = 1'b1;
        iabort      = 1'b0;
        tick();
        for (int k = 1; k <= 5000; k++) begin
            if (single && k == 1 + n * (d + 1)) begin
                istart = 1'b0;
                set_exp(0, 1'b0, 1'b0, 1'b1);
                tick();
                set_exp(0, 1'b0, 1'b0, 1'b0);
                return;
            end
            idx = (k - 1) / (d + 1);
            set_exp(vals[idx], ((k - 1) % (d + 1)) == 0, 1'b1, 1'b0);
            if (k == abort_k) begin
                istart = 1'b0; iabort = 1'b1;
                tick();
                iabort = 1'b0;
                set_exp(0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (k == reset_k) begin
                istart = 1'b0; ireset = 1'b1;
                tick();
                ireset = 1'b0;
                set_exp(0, 1'b0, 1'b0, 1'b0);
                return;
            end
            istart = ($urandom_range(0, 3) == 0);
            scramble();
            tick();
        end
        istart = 1'b0;
    endtask

    initial begin
        int s, e, inc, d, m, ak;
        ireset = 1'b1; istart = 1'b0; iabort = 1'b0;
        istep_start = 9'd0; istep_stop = 9'd0; istep_inc = 9'd0; idwell = 16'd0; imode = 2'd0;
        tick();
        set_exp(0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        tick();
        ireset = 1'b0;
        tick();

        run(1, 7, 1, 3, 0, 0, 0);
        run(0, 8, 3, 0, 0, 0, 0);
        run(2, -2, -1, 1, 0, 0, 0);
        run(1, 3, 1, 0, 2, 20, 0);
        run(-3, 0, 1, 2, 1, 30, 0);
        run(5, -4, 0, 2, 0, 0, 0);
        run(4, 4, 3, 1, 2, 9, 0);
        run(5, 0, 2, 0, 2, 12, 0);
        run(-256, 255, -256, 0, 2, 10, 0);
        run(3, 3, 1, 2, 3, 0, 0);

        // start together with abort in IDLE must be refused
        istep_start = 9'd5; istep_stop = 9'd9; istep_inc = 9'd1; idwell = 16'd0; imode = 2'd0;
        istart = 1'b1; iabort = 1'b1;
        tick();
        istart = 1'b0; iabort = 1'b0;
        tick();

        run(1, 7, 1, 3, 0, 0, 10);
        run(1, 7, 1, 3, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 1) == 0) begin
                s   = $urandom_range(0, 80) - 40;
                e   = $urandom_range(0, 80) - 40;
                inc = $urandom_range(0, 16) - 8;
            end else begin
                s   = $urandom_range(0, 511) - 256;
                e   = $urandom_range(0, 511) - 256;
                inc = $urandom_range(0, 511) - 256;
            end
            d  = $urandom_range(0, 3);
            m  = $urandom_range(0, 3);
            ak = $urandom_range(3, 60);
            if ((m == 0 || m == 3) && $urandom_range(0, 1) == 0) ak = 0;
            run(s, e, inc, d, m, ak, 0);
        end

        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
